// File: rtl/uart_text_dump.sv
// Streams a ROWS x COLS text RAM out as 8N1 UART, row-major, with CR/LF
// appended after each row.
module uart_text_dump #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600,
   parameter int COLS     = 32,
   parameter int ROWS     = 4,
   localparam int CW      = $clog2(COLS),
   localparam int RW      = $clog2(ROWS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic [RW-1:0] rd_row,
   output logic [CW-1:0] rd_col,
   input  logic [7:0]    rd_data,
   output logic          tx,
   output logic          busy,
   output logic          done
);

   localparam int CPB  = CLK_FREQ / BAUD;
   localparam int CNTW = $clog2(CPB);

   typedef enum logic [2:0] {
      IDLE, FETCH, WAIT, SEND, EOL_CR, EOL_LF, FIN
   } state_t;

   typedef enum logic [1:0] {
      K_CHAR, K_CR, K_LF
   } kind_t;

   state_t          state_q;
   kind_t           kind_q;
   logic [RW-1:0]   row_q;
   logic [CW-1:0]   col_q;
   logic [CNTW-1:0] cnt_q;
   logic [3:0]      bit_q;
   logic [8:0]      sh_q;
   logic            gap_q;
   logic            tx_q;
   logic            busy_q;
   logic            done_q;

   // Non-printables become '.' so a terminal never sees control codes.
   function automatic logic [7:0] map_char(input logic [7:0] d);
      logic [7:0] b;
      b = {1'b0, d[6:0]};
      if (b < 8'h20 || b == 8'h7F)
         b = 8'h2E;
      return b;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         kind_q  <= K_CHAR;
         row_q   <= '0;
         col_q   <= '0;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '1;
         gap_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= FETCH;
                  busy_q  <= 1'b1;
                  row_q   <= '0;
                  col_q   <= '0;
               end
            end
            FETCH: state_q <= WAIT;
            WAIT: begin
               sh_q    <= {1'b1, map_char(rd_data)};
               kind_q  <= K_CHAR;
               tx_q    <= 1'b0;
               cnt_q   <= '0;
               bit_q   <= '0;
               state_q <= SEND;
            end
            EOL_CR, EOL_LF: begin
               if (!gap_q) begin
                  gap_q <= 1'b1;
               end else begin
                  gap_q   <= 1'b0;
                  sh_q    <= {1'b1, (state_q == EOL_CR) ? 8'h0D : 8'h0A};
                  kind_q  <= (state_q == EOL_CR) ? K_CR : K_LF;
                  tx_q    <= 1'b0;
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (cnt_q == CNTW'(CPB - 1)) begin
                  cnt_q <= '0;
                  if (bit_q == 4'd9) begin
                     tx_q <= 1'b1;
                     unique case (kind_q)
                        K_CHAR: begin
                           if (col_q == CW'(COLS - 1)) begin
                              state_q <= EOL_CR;
                           end else begin
                              col_q   <= col_q + 1'b1;
                              state_q <= FETCH;
                           end
                        end
                        K_CR: state_q <= EOL_LF;
                        K_LF: begin
                           if (row_q == RW'(ROWS - 1)) begin
                              state_q <= FIN;
                              busy_q  <= 1'b0;
                              done_q  <= 1'b1;
                           end else begin
                              row_q   <= row_q + 1'b1;
                              col_q   <= '0;
                              state_q <= FETCH;
                           end
                        end
                        default: state_q <= IDLE;
                     endcase
                  end else begin
                     // sh_q carries the stop bit above the data byte
                     bit_q <= bit_q + 1'b1;
                     tx_q  <= sh_q[0];
                     sh_q  <= {1'b1, sh_q[8:1]};
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            FIN:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rd_row = row_q;
   assign rd_col = col_q;
   assign tx     = tx_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_uart_text_dump.sv
// Directed bench for uart_text_dump: 4x2 buffer, 4 clks per bit,
// exact cycle-by-cycle check of the serial line against the frame layout.
module tb_uart_text_dump;

   localparam int NF = 12;
   localparam int FL = 42;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [0:0] rd_row;
   logic [1:0] rd_col;
   logic [7:0] rd_data = 8'h00;
   logic       tx;
   logic       busy;
   logic       done;
   logic [7:0] mem [8];

   int tests = 0;
   int fails = 0;

   typedef struct {
      string        name;
      logic [63:0]  ram;
      logic [95:0]  exp;
      bit           stray;
   } vec_t;

   vec_t vt[3];

   uart_text_dump #(
      .CLK_FREQ(8),
      .BAUD    (2),
      .COLS    (4),
      .ROWS    (2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .rd_row (rd_row),
      .rd_col (rd_col),
      .rd_data(rd_data),
      .tx     (tx),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= mem[{rd_row, rd_col}];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", nm, act, req);
      end
   endtask

   task automatic load(input int vi);
      for (int i = 0; i < 8; i++)
         mem[i] = vt[vi].ram[8*(7-i) +: 8];
   endtask

   task automatic run_dump(input int vi);
      logic [7:0] got [NF];
      int         terr [NF];
      int         ndone, berr, xerr;
      int         d, f, r, b;
      logic       e;
      ndone = 0; berr = 0; xerr = 0;
      for (int i = 0; i < NF; i++) begin
         got[i] = 8'h00;
         terr[i] = 0;
      end
      load(vi);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int k = 0; k < 506; k++) begin
         d = k - 2;
         e = 1'b1;
         f = -1;
         if (d >= 0 && d < NF * FL) begin
            f = d / FL;
            r = d % FL;
            if (r < 40) begin
               b = r / 4;
               if (b == 0)
                  e = 1'b0;
               else if (b <= 8)
                  e = vt[vi].exp[8*(NF-1-f) + b - 1];
               if (b >= 1 && b <= 8 && r % 4 == 2)
                  got[f][b-1] = tx;
            end
         end
         if (tx !== e) begin
            if (f >= 0) terr[f]++;
            else xerr++;
         end
         if (done === 1'b1) ndone++;
         if (busy !== (k < 504)) berr++;
         if (k == 504)
            check({vt[vi].name, " done at T+504"}, 32'(done), 32'd1);
         start = vt[vi].stray && (k == 99);
         @(negedge clk);
      end
      start = 1'b0;
      for (int i = 0; i < NF; i++)
         check($sformatf("%s frame%0d {timing_errs,byte}", vt[vi].name, i),
               {terr[i][23:0], got[i]},
               {24'd0, vt[vi].exp[8*(NF-1-i) +: 8]});
      check({vt[vi].name, " idle-line errs"}, 32'(xerr), 32'd0);
      check({vt[vi].name, " done pulses"}, 32'(ndone), 32'd1);
      check({vt[vi].name, " busy errs"}, 32'(berr), 32'd0);
   endtask

   initial begin
      int errs;
      vt[0] = '{"abcd", 64'h41424344_7778797A,
                96'h41424344_0D0A_7778797A_0D0A, 1'b0};
      vt[1] = '{"ctrl", 64'h077FC120_1F7EFF00,
                96'h2E2E4120_0D0A_2E7E2E2E_0D0A, 1'b1};
      vt[2] = '{"edge", 64'h55AA803F_A09F6061,
                96'h552A2E3F_0D0A_202E6061_0D0A, 1'b0};
      load(0);

      repeat (3) @(negedge clk);
      check("reset tx", 32'(tx), 32'd1);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset addr", 32'({rd_row, rd_col}), 32'd0);
      reset = 1'b0;

      errs = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
             {rd_row, rd_col} !== 3'd0)
            errs++;
      end
      check("idle 50 clks", 32'(errs), 32'd0);

      for (int v = 0; v < 3; v++) begin
         run_dump(v);
         repeat (5) @(negedge clk);
      end

      // abort in the middle of a data bit of the third frame
      load(0);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (99) @(negedge clk);
      check("mid-frame busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("abort tx", 32'(tx), 32'd1);
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort addr", 32'({rd_row, rd_col}), 32'd0);
      reset = 1'b0;
      errs = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            errs++;
      end
      check("post-abort quiet", 32'(errs), 32'd0);
      run_dump(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
